// File: rtl/viterbi_pmu.sv
// Path-metric unit for a K=3, rate-1/2 Viterbi decoder. Four parallel ACS
// lanes feed a same-cycle min-normalisation and best-state search.

module viterbi_acs (
    input  logic [3:0] pm_p0,
    input  logic [3:0] pm_p1,
    input  logic [1:0] bm_p0,
    input  logic [1:0] bm_p1,
    output logic [3:0] metric,
    output logic       dec
);
    localparam logic [3:0] INF = 4'hF;

    logic [4:0] sum0, sum1;
    logic [3:0] c0, c1;

    // A sum of exactly 15 already reads as INF, so only >15 needs clamping.
    always_comb begin
        sum0   = {1'b0, pm_p0} + {3'b000, bm_p0};
        sum1   = {1'b0, pm_p1} + {3'b000, bm_p1};
        c0     = (pm_p0 == INF || sum0 > 5'd15) ? INF : sum0[3:0];
        c1     = (pm_p1 == INF || sum1 > 5'd15) ? INF : sum1[3:0];
        dec    = (c1 < c0);
        metric = dec ? c1 : c0;
    end
endmodule

module viterbi_pmu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [1:0]  bm0,
    input  logic [1:0]  bm1,
    input  logic [1:0]  bm2,
    input  logic [1:0]  bm3,
    output logic [15:0] pm,
    output logic [3:0]  decisions,
    output logic        out_valid,
    output logic [1:0]  best_state
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 4;
    localparam logic [VEC_W-1:0] INF = '1;
    localparam logic [NUM_LANES-1:0][VEC_W-1:0] PM_INIT = 16'hFFF0;
    // Branch-metric index per next state for the p0 / p1 predecessor.
    localparam logic [NUM_LANES-1:0][1:0] BM_SEL_P0 = {2'd1, 2'd3, 2'd2, 2'd0};
    localparam logic [NUM_LANES-1:0][1:0] BM_SEL_P1 = {2'd2, 2'd0, 2'd1, 2'd3};

    logic [NUM_LANES-1:0][VEC_W-1:0] pm_q, src_pm, raw, norm;
    logic [NUM_LANES-1:0][1:0]       bm_vec;
    logic [NUM_LANES-1:0]            dec_raw, dec_q;
    logic [VEC_W-1:0]                raw_min, norm_min;
    logic [1:0]                      best_nxt, best_q;
    logic                            vld_q;

    assign bm_vec = {bm3, bm2, bm1, bm0};
    assign src_pm = start ? PM_INIT : pm_q;

    generate
        for (genvar ns = 0; ns < NUM_LANES; ns++) begin : g_acs
            localparam int P0 = (ns % 2) * 2;
            viterbi_acs u_acs (
                .pm_p0  (src_pm[P0]),
                .pm_p1  (src_pm[P0+1]),
                .bm_p0  (bm_vec[BM_SEL_P0[ns]]),
                .bm_p1  (bm_vec[BM_SEL_P1[ns]]),
                .metric (raw[ns]),
                .dec    (dec_raw[ns])
            );
        end
    endgenerate

    // Strict '<' in the search keeps the lowest index on a tie; all-INF gives 0.
    always_comb begin
        raw_min = INF;
        for (int i = 0; i < NUM_LANES; i++)
            if (raw[i] < raw_min) raw_min = raw[i];
        for (int i = 0; i < NUM_LANES; i++)
            norm[i] = (raw[i] == INF) ? INF : raw[i] - raw_min;
        norm_min = INF;
        best_nxt = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (norm[i] < norm_min) begin
                norm_min = norm[i];
                best_nxt = 2'(i);
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q   <= PM_INIT;
            dec_q  <= '0;
            best_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                pm_q   <= norm;
                dec_q  <= dec_raw;
                best_q <= best_nxt;
            end else if (start) begin
                pm_q   <= PM_INIT;
                dec_q  <= '0;
                best_q <= '0;
            end
        end
    end

    assign pm         = pm_q;
    assign decisions  = dec_q;
    assign best_state = best_q;
    assign out_valid  = vld_q;
endmodule

// File: tb/tb_viterbi_pmu.sv
// Bench for viterbi_pmu: directed trellis cases plus random symbols checked
// against a transition-level model built from the generator polynomials.

module tb_viterbi_pmu;
    logic        clk = 1'b0;
    logic        rst_n, start, in_valid;
    logic [1:0]  bm0, bm1, bm2, bm3;
    logic [15:0] pm;
    logic [3:0]  decisions;
    logic        out_valid;
    logic [1:0]  best_state;

    int n_cmp = 0;
    int n_err = 0;
    int m_pm[4];
    int m_dec, m_best, m_ov;
    int mb[4];

    always #5 clk = ~clk;

    viterbi_pmu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .bm0        (bm0),
        .bm1        (bm1),
        .bm2        (bm2),
        .bm3        (bm3),
        .pm         (pm),
        .decisions  (decisions),
        .out_valid  (out_valid),
        .best_state (best_state)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pm = '{0, 15, 15, 15};
        m_dec = 0; m_best = 0; m_ov = 0;
    endtask

    // Walk every (state, input) transition; codeword indexes the branch metric.
    task automatic model_step(input bit st, input bit v);
        int src[4], raw[4], dec[4], mn, ns, cw, sum, cand;
        if (v) begin
            src = st ? '{0, 15, 15, 15} : m_pm;
            for (int i = 0; i < 4; i++) begin raw[i] = 16; dec[i] = 0; end
            for (int s = 0; s < 4; s++)
                for (int u = 0; u < 2; u++) begin
                    ns   = u * 2 + (s >> 1);
                    cw   = ((u ^ (s >> 1) ^ (s & 1)) << 1) | (u ^ (s & 1));
                    sum  = src[s] + mb[cw];
                    cand = (src[s] == 15 || sum > 15) ? 15 : sum;
                    if (cand < raw[ns]) begin raw[ns] = cand; dec[ns] = s & 1; end
                end
            mn = 15;
            for (int i = 0; i < 4; i++) if (raw[i] < mn) mn = raw[i];
            m_dec = 0;
            for (int i = 0; i < 4; i++) begin
                m_pm[i] = (raw[i] == 15) ? 15 : raw[i] - mn;
                m_dec |= dec[i] << i;
            end
            m_best = 0;
            for (int i = 3; i >= 0; i--) if (m_pm[i] <= m_pm[m_best]) m_best = i;
            if (m_pm[m_best] == 15) m_best = 0;
            m_ov = 1;
        end else if (st) begin
            model_reset();
        end else begin
            m_ov = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e;
        e = '0;
        for (int i = 0; i < 4; i++) e[4*i +: 4] = 4'(m_pm[i]);
        check({tag, ".pm"}, pm, e);
        check({tag, ".dec"}, 16'(decisions), 16'(m_dec));
        check({tag, ".best"}, 16'(best_state), 16'(m_best));
        check({tag, ".ovld"}, 16'(out_valid), 16'(m_ov));
    endtask

    task automatic step(input string tag, input bit st, input bit v,
                        input int b0, input int b1, input int b2, input int b3);
        start = st; in_valid = v;
        bm0 = 2'(b0); bm1 = 2'(b1); bm2 = 2'(b2); bm3 = 2'(b3);
        mb = '{b0, b1, b2, b3};
        @(posedge clk); #1;
        model_step(st, v);
        start = 1'b0; in_valid = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        bm0 = '0; bm1 = '0; bm2 = '0; bm3 = '0;
        model_reset();
        #12;
        check("rst.pm", pm, 16'hFFF0);
        check("rst.ovld", 16'(out_valid), 16'h0);
        check_all("rst");
        @(posedge clk); #1; rst_n = 1'b1;

        // Two symbols from reset metrics, no start required.
        step("a1", 0, 1, 0, 1, 1, 2);
        check("a1.const", pm, 16'hF2F0);
        check("a1.dec_tie", 16'(decisions), 16'h0);
        step("a2", 0, 1, 0, 1, 1, 2);
        check("a2.const", pm, 16'h3230);

        // Start then two symbols; second result needs normalisation.
        step("b0", 1, 0, 0, 0, 0, 0);
        check("b0.init", pm, 16'hFFF0);
        step("b1", 0, 1, 2, 1, 1, 0);
        check("b1.const", pm, 16'hF0F2);
        step("b2", 0, 1, 2, 1, 1, 0);
        check("b2.const", pm, 16'h0103);
        check("b2.best", 16'(best_state), 16'h1);

        // Gaps hold outputs; then start with a symbol restarts the trellis.
        step("g1", 0, 0, 3, 3, 3, 3);
        step("g2", 0, 0, 1, 2, 0, 1);
        check("g2.hold", pm, 16'h0103);
        step("g3", 0, 1, 1, 0, 2, 1);
        step("r1", 1, 1, 0, 1, 1, 2);
        check("r1.const", pm, 16'hF2F0);

        // Asynchronous reset mid-frame, away from any edge.
        step("r2", 0, 1, 2, 0, 1, 1);
        #2; rst_n = 1'b0; #1;
        model_reset();
        check("arst.pm", pm, 16'hFFF0);
        check_all("arst");
        @(posedge clk); #1; rst_n = 1'b1;

        for (int n = 0; n < 300; n++)
            step("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
